// File: rtl/nanov_periph_pkg.sv
// -----------------------------------------------------------------------------
// nanov_periph_pkg
//   Shared definitions for nanoV memory-mapped peripherals.
//   - cap_state_e : receive-capture FSM encoding (IDLE, ACK, WAIT)
//   - ST_*        : bit positions inside the UART status byte
//   - UART_*_ADDR : bus addresses decoded by the top-level data_in mux
//   - pack_status : assembles the UART status byte from its fields
// -----------------------------------------------------------------------------
package nanov_periph_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ACK  = 2'd1,
    CAP_WAIT = 2'd2
  } cap_state_e;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_CNT_LSB   = 4;

  localparam logic [31:0] UART_DATA_ADDR   = 32'h1000_1000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_1004;

  // Bit 3 is reserved and always reads 0.
  function automatic logic [7:0] pack_status(
    input logic       not_empty,
    input logic       full,
    input logic       ovf,
    input logic [3:0] cnt
  );
    logic [7:0] s;
    s                          = 8'h00;
    s[ST_NOT_EMPTY]            = not_empty;
    s[ST_FULL]                 = full;
    s[ST_OVF]                  = ovf;
    s[ST_CNT_LSB +: 4]         = cnt;
    return s;
  endfunction

endpackage : nanov_periph_pkg

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
//   Groups the uart_rx handshake and the CPU bus-side signals of the receive
//   FIFO.
//   uart_rx side : rx_valid, rx_data (to FIFO), rx_ack (from FIFO)
//   CPU side     : rd_en, clr_ovf (to FIFO), rd_data, status (from FIFO)
//   modport slave  : the FIFO itself
//   modport master : whoever drives uart_rx / the CPU strobes
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       rd_en;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic [7:0] status;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ack,
    input  rd_en,
    input  clr_ovf,
    output rd_data,
    output status
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ack,
    output rd_en,
    output clr_ovf,
    input  rd_data,
    input  status
  );

endinterface : uart_rx_fifo_if

// File: rtl/uart_rx_fifo_core.sv
// -----------------------------------------------------------------------------
// sync_fifo_core
//   Single-clock FIFO: storage, read/write pointers and occupancy count.
//   A pop while empty is ignored. A push while full is ignored unless a valid
//   pop happens in the same cycle, in which case both take effect.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     push_i       : write wdata_i at the tail
//     pop_i        : advance the head
//     wdata_i      : data to write
//     head_o       : raw storage word at the head (meaningless when empty)
//     count_o      : occupancy, 0..DEPTH
//     full_o       : count_o == DEPTH
//     empty_o      : count_o == 0
// -----------------------------------------------------------------------------
module sync_fifo_core #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic pop_eff;
  logic push_eff;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push needs, so full only blocks a
  // push when no pop accompanies it.
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale contents are never observable and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : sync_fifo_core

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer between uart_rx and the nanoV data bus. Each byte
//   offered by uart_rx is acknowledged exactly once and queued; bytes arriving
//   while the queue is full are acknowledged, dropped and flagged in a sticky
//   overflow bit.
//   Parameters: DEPTH (2, 4 or 8 entries), PTR_W = log2(DEPTH).
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : uart_rx_fifo_if.slave
//             rx_valid/rx_data in, rx_ack out  (uart_rx handshake)
//             rd_en/clr_ovf in                  (CPU pop / clear strobes)
//             rd_data out : head byte, 0x00 when empty
//             status  out : [0] not_empty [1] full [2] overflow [3] 0
//                           [7:4] count
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import nanov_periph_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  uart_rx_fifo_if.slave    bus
);

  localparam logic [1:0] S_IDLE = CAP_IDLE;
  localparam logic [1:0] S_ACK  = CAP_ACK;
  localparam logic [1:0] S_WAIT = CAP_WAIT;

  logic [1:0]     state_q, state_d;
  logic           ovf_q,   ovf_d;
  logic           rx_ack;
  logic           drop;

  logic [7:0]     head;
  logic [PTR_W:0] count;
  logic           full;
  logic           empty;

  // ---------------------------------------------------------------------------
  // Capture FSM. Acknowledging only from IDLE, then waiting for rx_valid to
  // fall, guarantees one push per byte even if uart_rx drops valid late.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rx_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          rx_ack  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:  state_d = S_WAIT;
      S_WAIT: if (!bus.rx_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO is never empty, so any rd_en in that cycle is a real pop that
  // makes room; only a push without one is dropped.
  assign drop = rx_ack && full && !bus.rd_en;

  // A fresh overflow outranks a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)              ovf_d = 1'b1;
    else if (bus.clr_ovf)  ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo_core #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (8)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_ack),
    .pop_i   (bus.rd_en),
    .wdata_i (bus.rx_data),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.rx_ack  = rx_ack;
  assign bus.rd_data = empty ? 8'h00 : head;
  assign bus.status  = pack_status(!empty, full, ovf_q, 4'(count));

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo. Accepted bytes are queued as expected
//   pop data when sent; a monitor compares rd_data against that queue on
//   every pop. Status, rx_ack and ack pulse counts are checked inline.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .DEPTH (8),
    .PTR_W (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ack_cnt  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Count rx_ack pulses and score every pop against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_ack) ack_cnt++;
      if (bus.rd_en) begin
        if (exp_q.size() == 0) mon_exp = 8'h00;
        else                   mon_exp = exp_q.pop_front();
        check("pop_data", {24'h0, bus.rd_data}, {24'h0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte, hold rx_valid for 'hold' cycles, then release it.
  task automatic send(input logic [7:0] b, input bit accept, input int hold);
    int a0;
    a0 = ack_cnt;
    if (accept) exp_q.push_back(b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    repeat (hold) tick();
    bus.rx_valid = 1'b0;
    repeat (2) tick();
    check("ack_pulses", ack_cnt, a0 + 1);
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_status", bus.status, 8'h00);
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_rx_ack", bus.rx_ack, 1'b0);

    // Single byte held for 4 cycles
    send(8'hA5, 1'b1, 4);
    check("single_status", bus.status, 8'h11);
    check("single_rd_data", bus.rd_data, 8'hA5);
    pop();
    check("single_after_pop", bus.status, 8'h00);

    // Fill, overflow, clear race
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b1, 2);
    check("fill_status", bus.status, 8'h83);
    send(8'h09, 1'b0, 2);
    check("ovf_status", bus.status, 8'h87);
    bus.clr_ovf  = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h0A;
    tick();
    bus.clr_ovf = 1'b0;
    tick();
    bus.rx_valid = 1'b0;
    repeat (2) tick();
    check("clr_race_status", bus.status, 8'h87);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("clr_alone_status", bus.status, 8'h83);
    repeat (8) pop();
    check("drain_status", bus.status, 8'h00);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 1'b1, 2);
    exp_q.push_back(8'h55);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    bus.rd_en    = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tick();
    bus.rx_valid = 1'b0;
    repeat (2) tick();
    check("full_pushpop_status", bus.status, 8'h83);
    repeat (7) pop();
    check("last_head", bus.rd_data, 8'h55);
    pop();
    check("full_drain_status", bus.status, 8'h00);

    // Empty pop
    pop();
    check("empty_pop_status", bus.status, 8'h00);

    // Pointer wrap: 20 push/pop pairs
    for (int i = 0; i < 20; i++) begin
      send(8'(i * 7 + 3), 1'b1, 2);
      pop();
    end
    check("wrap_status", bus.status, 8'h00);
    check("wrap_queue_empty", exp_q.size(), 0);

    // Reset mid-operation empties the FIFO
    send(8'hC3, 1'b1, 2);
    send(8'h3C, 1'b1, 2);
    check("pre_reset_status", bus.status, 8'h21);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_status", bus.status, 8'h00);
    check("midrst_rd_data", bus.rd_data, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_fifo
